// File: rtl/pa_tcipif_pkg.sv
// Shared definitions for the tcipif initiator: FSM encoding, CLINT window base and register offsets.
// The optional bus timeout is enabled with the TCIPIF_MST_TIMEOUT_EN macro (see pa_tcipif_mst.sv).
package pa_tcipif_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_BUS_ENC  = 2'd1;
    localparam logic [1:0] ST_RESP_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_BUS  = ST_BUS_ENC,
        ST_RESP = ST_RESP_ENC
    } tcipif_state_e;

    localparam logic [31:0] CLINT_BASE_DFLT  = 32'hE000_0000;
    localparam int          TIMEOUT_CYC_DFLT = 16;

    localparam logic [15:0] CLINT_MSIP       = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMPLO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMPHI = 16'h4004;
    localparam logic [15:0] CLINT_MTIMELO    = 16'hbff8;
    localparam logic [15:0] CLINT_MTIMEHI    = 16'hbffc;

    // A request targets the CLINT only if it falls in the 64KB window and is word aligned.
    function automatic logic clint_hit(input logic [15:0] addr_hi, input logic [1:0] addr_lo,
                                       input logic [15:0] base_hi);
        return (addr_hi == base_hi) && (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/pa_tcipif_mst_tmo.sv
// Bus-phase timeout counter for the tcipif initiator; only instantiated when
// TCIPIF_MST_TIMEOUT_EN is defined.
module pa_tcipif_mst_tmo #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam logic [4:0] LAST_CNT = 5'(TIMEOUT_CYC - 1);

    logic [4:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 5'd0;
        end else if (i_clr) begin
            r_cnt <= 5'd0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    // Fires in the cycle whose increment would reach TIMEOUT_CYC, so sel is high exactly TIMEOUT_CYC cycles.
    assign o_expire = i_inc && (r_cnt == LAST_CNT);

endmodule

// File: rtl/pa_tcipif_mst.sv
// Initiator end of the tcipif link to the CLINT: one request in flight, decode, bus phase, response.
// Define TCIPIF_MST_TIMEOUT_EN to abort a bus phase that gets no cmplt within TIMEOUT_CYC cycles.
module pa_tcipif_mst
    import pa_tcipif_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE  = CLINT_BASE_DFLT,
    parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        lsu_tcipif_req_vld,
    input  logic [31:0] lsu_tcipif_addr,
    input  logic        lsu_tcipif_write,
    input  logic [31:0] lsu_tcipif_wdata,
    output logic        tcipif_lsu_req_rdy,
    output logic        tcipif_lsu_resp_vld,
    output logic [31:0] tcipif_lsu_rdata,
    output logic        tcipif_lsu_err,
    input  logic        lsu_tcipif_resp_rdy,
    output logic        tcipif_clint_sel,
    output logic [15:0] tcipif_clint_addr,
    output logic        tcipif_clint_write,
    output logic [31:0] tcipif_clint_wdata,
    input  logic        clint_tcipif_cmplt,
    input  logic [31:0] clint_tcipif_rdata,
    output logic [1:0]  o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready
    // and payload is held stable while valid is high and ready is low.

    tcipif_state_e r_state;
    logic          r_req_rdy;
    logic          r_resp_vld;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          r_sel;
    logic [15:0]   r_addr;
    logic          r_write;
    logic [31:0]   r_wdata;

    logic w_accept;
    logic w_hit;
    logic w_tmo_expire;

    assign w_accept = lsu_tcipif_req_vld && r_req_rdy;
    assign w_hit    = clint_hit(lsu_tcipif_addr[31:16], lsu_tcipif_addr[1:0], CLINT_BASE[31:16]);

`ifdef TCIPIF_MST_TIMEOUT_EN
    pa_tcipif_mst_tmo #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .i_clk    (forever_cpuclk),
        .i_rst    (cpurst),
        .i_clr    (w_accept),
        .i_inc    ((r_state == ST_BUS) && !clint_tcipif_cmplt),
        .o_expire (w_tmo_expire)
    );
`else
    assign w_tmo_expire = 1'b0;
`endif

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_state    <= ST_IDLE;
            r_req_rdy  <= 1'b1;
            r_resp_vld <= 1'b0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
            r_sel      <= 1'b0;
            r_addr     <= 16'd0;
            r_write    <= 1'b0;
            r_wdata    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_rdy <= 1'b0;
                        if (w_hit) begin
                            r_state <= ST_BUS;
                            r_sel   <= 1'b1;
                            r_addr  <= lsu_tcipif_addr[15:0];
                            r_write <= lsu_tcipif_write;
                            r_wdata <= lsu_tcipif_wdata;
                        end else begin
                            // Decode miss answers directly without touching the bus.
                            r_state    <= ST_RESP;
                            r_resp_vld <= 1'b1;
                            r_err      <= 1'b1;
                            r_rdata    <= 32'd0;
                        end
                    end
                end
                ST_BUS: begin
                    if (clint_tcipif_cmplt || w_tmo_expire) begin
                        r_state    <= ST_RESP;
                        r_sel      <= 1'b0;
                        r_addr     <= 16'd0;
                        r_write    <= 1'b0;
                        r_wdata    <= 32'd0;
                        r_resp_vld <= 1'b1;
                        // cmplt takes priority over a coincident timeout.
                        r_err      <= !clint_tcipif_cmplt;
                        r_rdata    <= (clint_tcipif_cmplt && !r_write) ? clint_tcipif_rdata : 32'd0;
                    end
                end
                ST_RESP: begin
                    if (lsu_tcipif_resp_rdy) begin
                        r_state    <= ST_IDLE;
                        r_resp_vld <= 1'b0;
                        r_err      <= 1'b0;
                        r_rdata    <= 32'd0;
                        r_req_rdy  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_req_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign tcipif_lsu_req_rdy  = r_req_rdy;
    assign tcipif_lsu_resp_vld = r_resp_vld;
    assign tcipif_lsu_rdata    = r_rdata;
    assign tcipif_lsu_err      = r_err;
    assign tcipif_clint_sel    = r_sel;
    assign tcipif_clint_addr   = r_addr;
    assign tcipif_clint_write  = r_write;
    assign tcipif_clint_wdata  = r_wdata;
    assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_pa_tcipif_mst.sv
// Bench for pa_tcipif_mst: directed vector table, randomized transactions against a
// behavioural model, and reset/stall corner sequences. Honours TCIPIF_MST_TIMEOUT_EN.
module tb_pa_tcipif_mst;
  import pa_tcipif_pkg::*;

`ifdef TCIPIF_MST_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TMO    = 4;
  localparam int T4_DLY = TMO_EN ? 2 : 5;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_vld = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        req_rdy;
  logic        resp_vld;
  logic [31:0] rdata;
  logic        err;
  logic        resp_rdy = 1'b0;
  logic        sel;
  logic [15:0] clint_addr;
  logic        write;
  logic [31:0] wdata;
  logic        clint_cmplt;
  logic [31:0] clint_rdata;
  logic [1:0]  dbg_state;

  pa_tcipif_mst #(
    .CLINT_BASE  (32'hE000_0000),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .forever_cpuclk      (clk),
    .cpurst              (rst),
    .lsu_tcipif_req_vld  (req_vld),
    .lsu_tcipif_addr     (req_addr),
    .lsu_tcipif_write    (req_write),
    .lsu_tcipif_wdata    (req_wdata),
    .tcipif_lsu_req_rdy  (req_rdy),
    .tcipif_lsu_resp_vld (resp_vld),
    .tcipif_lsu_rdata    (rdata),
    .tcipif_lsu_err      (err),
    .lsu_tcipif_resp_rdy (resp_rdy),
    .tcipif_clint_sel    (sel),
    .tcipif_clint_addr   (clint_addr),
    .tcipif_clint_write  (write),
    .tcipif_clint_wdata  (wdata),
    .clint_tcipif_cmplt  (clint_cmplt),
    .clint_tcipif_rdata  (clint_rdata),
    .o_dbg_state         (dbg_state)
  );

  // CLINT responder: answers after rsp_dly wait cycles, glitches cmplt/rdata while idle
  int          rsp_dly = 0;
  logic        rsp_off = 1'b0;
  int          sel_cnt = 0;
  logic        noise_c = 1'b0;
  logic [31:0] junk = '0;

  function automatic logic [31:0] rd_fn(input logic [15:0] off);
    return (off == 16'h0000) ? 32'h0000_0001 : {~off, off};
  endfunction

  assign clint_cmplt = sel ? (!rsp_off && (sel_cnt >= rsp_dly)) : noise_c;
  assign clint_rdata = (sel && clint_cmplt) ? rd_fn(clint_addr) : junk;

  always @(posedge clk) begin
    if (!sel || clint_cmplt) sel_cnt <= 0;
    else sel_cnt <= sel_cnt + 1;
  end

  always @(negedge clk) begin
    noise_c <= 1'($urandom_range(0, 1));
    junk    <= $urandom;
  end

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // behavioural reference: decode rule, timeout rule, read-data source
  function automatic void model(input logic [31:0] a, input logic w, input int d,
                                output logic e, output logic [31:0] rd, output int ns);
    bit hit;
    hit = ((a >> 16) == 32'h0000_E000) && ((a % 4) == 0);
    if (!hit) begin
      e = 1'b1; rd = '0; ns = 0;
    end else if (TMO_EN && (d + 1 > TMO)) begin
      e = 1'b1; rd = '0; ns = TMO;
    end else begin
      e = 1'b0; rd = w ? 32'd0 : rd_fn(a[15:0]); ns = d + 1;
    end
  endfunction

  // driver: one full transaction with monitoring; optionally pre-drives the next request
  task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input int dly, input int rwait,
                        input logic exp_err, input logic [31:0] exp_rd, input int exp_sel,
                        input bit nxt_en, input logic [31:0] na, input logic nw,
                        input logic [31:0] nwd);
    int   waitc;
    int   selc;
    int   lat;
    logic r;
    bit   done;
    rsp_dly   = dly;
    req_vld   = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = wd;
    waitc = 0;
    do begin
      r = req_rdy;
      @(posedge clk); #1;
      waitc++;
    end while (!r && waitc < 50);
    chk("accept", 64'(r), 64'(1));
    if (nxt_en) begin
      req_addr = na; req_write = nw; req_wdata = nwd;
    end else begin
      req_vld = 1'b0;
    end
    selc = 0; lat = 0; done = 0;
    while (!done && lat < 300) begin
      lat++;
      if (sel) begin
        selc++;
        chk("bus_drive", {31'd0, write, clint_addr, wd[31:16], wdata[15:0]} ^ {wdata[31:16], 48'd0},
            {31'd0, w, a[15:0], wd[31:16], wd[15:0]} ^ {wd[31:16], 48'd0});
      end else begin
        chk("bus_idle_zero", {31'd0, write, wdata}, 64'd0);
      end
      chk("req_rdy_busy", 64'(req_rdy), 64'd0);
      if (resp_vld) done = 1;
      else begin @(posedge clk); #1; end
    end
    chk("resp_latency", 64'(lat), 64'(exp_sel + 1));
    chk("sel_cycles", 64'(selc), 64'(exp_sel));
    if (!done) return;
    exp_q.push_back(exp_rd);
    for (int k = 0; k < rwait; k++) begin
      chk("resp_hold", {31'd0, resp_vld, err, req_rdy, rdata}, {31'd0, 1'b1, exp_err, 1'b0, exp_rd});
      @(posedge clk); #1;
    end
    chk("resp", {31'd0, resp_vld, err, rdata}, {31'd0, 1'b1, exp_err, exp_q.pop_front()});
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    chk("after_handshake", {61'd0, resp_vld, req_rdy, sel}, 64'b010);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    int          dly;
    int          rw;
    logic        err;
    logic [31:0] rd;
    int          nsel;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic        e;
    logic [31:0] rd;
    int          ns;
    logic [31:0] a;
    logic        w;
    logic [31:0] wd;
    int          d;
    int          sel_hi;
    bit          vld_seen;

    tbl[0] = '{32'hE000_0000, 1'b0, 32'h0,          0,      0, 1'b0, 32'h0000_0001, 1};
    tbl[1] = '{32'hE000_4000, 1'b1, 32'h1234_5678,  0,      0, 1'b0, 32'h0,         1};
    tbl[2] = '{32'h4000_0000, 1'b0, 32'h0,          0,      0, 1'b1, 32'h0,         0};
    tbl[3] = '{32'hE000_0002, 1'b0, 32'h0,          0,      0, 1'b1, 32'h0,         0};
    tbl[4] = '{32'hE000_BFF8, 1'b0, 32'h0,          T4_DLY, 3, 1'b0, 32'h4007_BFF8, T4_DLY + 1};
    tbl[5] = '{32'hE000_0000, 1'b1, 32'h0000_0001,  1,      1, 1'b0, 32'h0,         2};
    tbl[6] = '{32'hE000_BFFC, 1'b0, 32'h0,          2,      0, 1'b0, 32'h4003_BFFC, 3};
    tbl[7] = '{32'hE001_0000, 1'b1, 32'hDEAD_BEEF,  0,      2, 1'b1, 32'h0,         0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {12'd0, req_rdy, sel, resp_vld, err, write, rdata, clint_addr},
        {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0});
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", {62'd0, req_rdy, sel}, 64'b10);

    // directed table; row 4 pre-drives row 5 to check back-to-back acceptance
    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].dly, tbl[i].rw,
             tbl[i].err, tbl[i].rd, tbl[i].nsel,
             (i == 4), tbl[5].addr, tbl[5].wr, tbl[5].wd);
    end

    // randomized transactions vs model
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: a = {16'hE000, 16'($urandom_range(0, 16'h3FFF) * 4)};
        1: a = {16'($urandom_range(0, 16'hDFFF)), 16'($urandom)};
        2: a = {16'hE000, 14'($urandom), 2'($urandom_range(1, 3))};
        default: begin
          case ($urandom_range(0, 4))
            0: a = {16'hE000, CLINT_MSIP};
            1: a = {16'hE000, CLINT_MTIMECMPLO};
            2: a = {16'hE000, CLINT_MTIMECMPHI};
            3: a = {16'hE000, CLINT_MTIMELO};
            default: a = {16'hE000, CLINT_MTIMEHI};
          endcase
        end
      endcase
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      d  = $urandom_range(0, TMO_EN ? 6 : 5);
      model(a, w, d, e, rd, ns);
      do_txn(a, w, wd, d, $urandom_range(0, 3), e, rd, ns, 1'b0, 32'd0, 1'b0, 32'd0);
    end

    // stuck responder: timeout (macro) or indefinite wait, then reset mid-BUS
    rsp_off = 1'b1;
`ifdef TCIPIF_MST_TIMEOUT_EN
    do_txn(32'hE000_0000, 1'b0, 32'd0, 0, 1, 1'b1, 32'd0, TMO, 1'b0, 32'd0, 1'b0, 32'd0);
`endif
    req_vld = 1'b1; req_addr = 32'hE000_4004; req_write = 1'b1; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_vld = 1'b0;
    sel_hi = 0;
    for (int k = 0; k < (TMO_EN ? TMO - 1 : 120); k++) begin
      if (sel && !resp_vld) sel_hi++;
      @(posedge clk); #1;
    end
    chk("sel_hold_no_cmplt", 64'(sel_hi), 64'(TMO_EN ? TMO - 1 : 120));
    chk("in_bus_before_reset", {63'd0, sel}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_bus", {60'd0, sel, resp_vld, err, req_rdy}, 64'b0001);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_off = 1'b0;
    vld_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (resp_vld || sel || !req_rdy) vld_seen = 1;
      @(posedge clk); #1;
    end
    chk("no_stale_after_reset", 64'(vld_seen), 64'd0);

    // reset while a response is pending
    req_vld = 1'b1; req_addr = 32'h1000_0000; req_write = 1'b0;
    @(posedge clk); #1;
    req_vld = 1'b0;
    chk("miss_resp_before_reset", {62'd0, resp_vld, err}, 64'b11);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_resp", {61'd0, resp_vld, err, req_rdy}, 64'b001);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // normal traffic after reset
    do_txn(32'hE000_BFFC, 1'b0, 32'd0, 1, 0, 1'b0, 32'h4003_BFFC, 2, 1'b0, 32'd0, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
